// File: rtl/peak_period_ctrl.sv
// Period scheduler and peak-hold readout arbiter: per-channel maxima, 1 ms snapshot, valid/ready readout.
// Optional build macro PEAK_SIGNED_EN selects signed samples with most-negative clear value.
module peak_period_ctrl #(
    parameter int NCH        = 4,
    parameter int DW         = 48,
    parameter int CHW        = 2,
    parameter int PW         = 18,
    parameter int PERIOD_DEF = 150000
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_en,
    input  logic [PW-1:0]  i_cfg_period,
    input  logic           i_in_valid,
    input  logic [CHW-1:0] i_in_ch,
    input  logic [DW-1:0]  i_in_data,
    output logic           o_period_tick,
    output logic           o_out_valid,
    input  logic           i_out_ready,
    output logic [CHW-1:0] o_out_ch,
    output logic [DW-1:0]  o_out_max,
    output logic           o_out_last,
    output logic           o_overrun,
    input  logic           i_clr_ovr
);

`ifdef PEAK_SIGNED_EN
    localparam logic [DW-1:0] CLR_VAL = {1'b1, {(DW-1){1'b0}}};
`else
    localparam logic [DW-1:0] CLR_VAL = '0;
`endif

    localparam logic [0:0]     S_IDLE   = 1'b0;
    localparam logic [0:0]     S_SEND   = 1'b1;
    localparam logic [PW-1:0]  PLEN_MIN = PW'(2);
    localparam logic [PW-1:0]  PLEN_RST = PW'(PERIOD_DEF);
    localparam logic [CHW-1:0] CH_LAST  = CHW'(NCH - 1);

    logic [PW-1:0]  r_count;
    logic [PW-1:0]  r_plen;
    logic [DW-1:0]  r_inner [NCH];
    logic [DW-1:0]  r_hold  [NCH];
    logic [0:0]     r_state;
    logic [CHW-1:0] r_out_ch;
    logic           r_overrun;

    logic [PW-1:0]  w_cfg_eff;
    logic           w_tick;
    logic [DW-1:0]  w_cur;
    logic           w_gt;
    logic           w_take;

    assign w_cfg_eff = (i_cfg_period < PLEN_MIN) ? PLEN_MIN : i_cfg_period;
    assign w_tick    = i_en && (r_count == (r_plen - PW'(1)));
    assign w_cur     = r_inner[i_in_ch];

    // Single shared comparator: only the addressed channel is compared each cycle.
`ifdef PEAK_SIGNED_EN
    assign w_gt = $signed(i_in_data) > $signed(w_cur);
`else
    assign w_gt = i_in_data > w_cur;
`endif
    assign w_take = i_in_valid && w_gt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
            r_plen  <= PLEN_RST;
        end else begin
            if (!i_en || w_tick)
                r_count <= '0;
            else
                r_count <= r_count + PW'(1);
            if (!i_en || w_tick)
                r_plen <= w_cfg_eff;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || !i_en || w_tick) begin
            for (int c = 0; c < NCH; c++)
                r_inner[c] <= CLR_VAL;
        end else if (w_take) begin
            r_inner[i_in_ch] <= i_in_data;
        end
    end

    // A sample landing on the tick cycle still belongs to the period that is ending.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int c = 0; c < NCH; c++)
                r_hold[c] <= CLR_VAL;
        end else if (w_tick && (r_state == S_IDLE)) begin
            for (int c = 0; c < NCH; c++)
                r_hold[c] <= (w_take && (i_in_ch == CHW'(c))) ? i_in_data : r_inner[c];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_out_ch <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_tick) begin
                        r_state  <= S_SEND;
                        r_out_ch <= '0;
                    end
                end
                default: begin
                    if (i_out_ready) begin
                        if (r_out_ch == CH_LAST) begin
                            r_state  <= S_IDLE;
                            r_out_ch <= '0;
                        end else begin
                            r_out_ch <= r_out_ch + CHW'(1);
                        end
                    end
                end
            endcase
        end
    end

    // A dropped snapshot takes priority over a simultaneous clear request.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_overrun <= 1'b0;
        else if (w_tick && (r_state == S_SEND))
            r_overrun <= 1'b1;
        else if (i_clr_ovr)
            r_overrun <= 1'b0;
    end

    assign o_period_tick = w_tick;
    assign o_out_valid   = (r_state == S_SEND);
    assign o_out_ch      = r_out_ch;
    assign o_out_max     = o_out_valid ? r_hold[r_out_ch] : '0;
    assign o_out_last    = o_out_valid && (r_out_ch == CH_LAST);
    assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_peak_period_ctrl.sv
// Self-checking bench for peak_period_ctrl: directed test-plan steps then randomized traffic against a queue-based model.
// Build with PEAK_SIGNED_EN defined to exercise the signed variant.
module tb_peak_period_ctrl;

    localparam int NCH = 4;
    localparam int DW  = 48;
    localparam int CHW = 2;
    localparam int PW  = 18;

`ifdef PEAK_SIGNED_EN
    localparam logic [DW-1:0] CLRV = {1'b1, {(DW-1){1'b0}}};
`else
    localparam logic [DW-1:0] CLRV = '0;
`endif

    logic           clk;
    logic           rst;
    logic           en;
    logic [PW-1:0]  cfgPeriod;
    logic           inValid;
    logic [CHW-1:0] inCh;
    logic [DW-1:0]  inData;
    logic           periodTick;
    logic           outValid;
    logic           outReady;
    logic [CHW-1:0] outCh;
    logic [DW-1:0]  outMax;
    logic           outLast;
    logic           overrun;
    logic           clrOvr;

    peak_period_ctrl #(.NCH(NCH), .DW(DW), .CHW(CHW), .PW(PW), .PERIOD_DEF(150000)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_en         (en),
        .i_cfg_period (cfgPeriod),
        .i_in_valid   (inValid),
        .i_in_ch      (inCh),
        .i_in_data    (inData),
        .o_period_tick(periodTick),
        .o_out_valid  (outValid),
        .i_out_ready  (outReady),
        .o_out_ch     (outCh),
        .o_out_max    (outMax),
        .o_out_last   (outLast),
        .o_overrun    (overrun),
        .i_clr_ovr    (clrOvr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int passCount = 0;
    int failCount = 0;
    int totalCount = 0;

    // Reference model: period counter as integers, readout as a queue of pending beats.
    typedef struct {
        logic [CHW-1:0] ch;
        logic [DW-1:0]  val;
    } beat_t;

    int            mCount;
    int            mPlen;
    logic [DW-1:0] mInner [NCH];
    beat_t         mQ [$];
    logic          mOvr;

    function automatic bit gtModel(logic [DW-1:0] a, logic [DW-1:0] b);
`ifdef PEAK_SIGNED_EN
        return $signed(a) > $signed(b);
`else
        return a > b;
`endif
    endfunction

    task automatic modelReset();
        mCount = 0;
        mPlen  = 150000;
        for (int c = 0; c < NCH; c++) mInner[c] = CLRV;
        mQ.delete();
        mOvr = 1'b0;
    endtask

    function automatic bit expTick();
        return en && (mCount == mPlen - 1);
    endfunction

    task automatic modelStep();
        int eff;
        bit tick;
        bit busy;
        beat_t b;
        logic [DW-1:0] snap;
        eff  = (int'(cfgPeriod) < 2) ? 2 : int'(cfgPeriod);
        tick = expTick();
        if (rst) begin
            modelReset();
            return;
        end
        busy = (mQ.size() > 0);
        if (tick && busy) mOvr = 1'b1;
        else if (clrOvr) mOvr = 1'b0;
        if (busy && outReady) void'(mQ.pop_front());
        if (tick && !busy) begin
            for (int c = 0; c < NCH; c++) begin
                snap = mInner[c];
                if (inValid && (int'(inCh) == c) && gtModel(inData, snap)) snap = inData;
                b.ch  = CHW'(c);
                b.val = snap;
                mQ.push_back(b);
            end
        end
        if (!en || tick) begin
            for (int c = 0; c < NCH; c++) mInner[c] = CLRV;
        end else if (inValid && gtModel(inData, mInner[inCh])) begin
            mInner[inCh] = inData;
        end
        if (!en || tick) begin
            mCount = 0;
            mPlen  = eff;
        end else begin
            mCount = mCount + 1;
        end
    endtask

    task automatic checkOutput(string tag, logic [63:0] observed, logic [63:0] expected);
        totalCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic compareModel();
        checkOutput("tick", periodTick, expTick());
        checkOutput("out_valid", outValid, mQ.size() > 0);
        if (mQ.size() > 0) begin
            checkOutput("out_ch", outCh, mQ[0].ch);
            checkOutput("out_max", outMax, mQ[0].val);
            checkOutput("out_last", outLast, int'(mQ[0].ch) == NCH - 1);
        end
        checkOutput("overrun", overrun, mOvr);
    endtask

    task automatic applyStimulus(input logic e, input logic [PW-1:0] cfg, input logic v,
                                 input logic [CHW-1:0] c, input logic [DW-1:0] d,
                                 input logic r, input logic clr);
        en        = e;
        cfgPeriod = cfg;
        inValid   = v;
        inCh      = c;
        inData    = d;
        outReady  = r;
        clrOvr    = clr;
    endtask

    task automatic cycle();
        #1;
        compareModel();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    // Checks four consecutive beats against fixed values while draining with out_ready high.
    task automatic checkBeats(string tag, logic [PW-1:0] cfg, logic [DW-1:0] e0, logic [DW-1:0] e1,
                              logic [DW-1:0] e2, logic [DW-1:0] e3);
        logic [DW-1:0] ev [4];
        ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
        for (int b = 0; b < 4; b++) begin
            checkOutput({tag, "_valid"}, outValid, 1'b1);
            checkOutput({tag, "_ch"}, outCh, b);
            checkOutput({tag, "_max"}, outMax, ev[b]);
            checkOutput({tag, "_last"}, outLast, b == 3);
            applyStimulus(1'b1, cfg, 1'b0, '0, '0, 1'b1, 1'b0);
            cycle();
        end
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [PW-1:0] cfgR;

        rst = 1'b1;
        applyStimulus(1'b0, PW'(8), 1'b0, '0, '0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        modelReset();
        checkOutput("rst_valid", outValid, 1'b0);
        checkOutput("rst_ch", outCh, 0);
        checkOutput("rst_max", outMax, 0);
        checkOutput("rst_last", outLast, 1'b0);
        checkOutput("rst_ovr", overrun, 1'b0);
        checkOutput("rst_tick", periodTick, 1'b0);
        cycle();
        rst = 1'b0;
        cycle();

        // Plan 1 and 2: basic period with maxima, then tick-cycle sample.
        for (int i = 0; i < 8; i++) begin
            case (i)
                0: applyStimulus(1'b1, PW'(8), 1'b1, 2'd0, 48'd5, 1'b1, 1'b0);
                1: applyStimulus(1'b1, PW'(8), 1'b1, 2'd0, 48'd9, 1'b1, 1'b0);
                2: applyStimulus(1'b1, PW'(8), 1'b1, 2'd0, 48'd3, 1'b1, 1'b0);
                3: applyStimulus(1'b1, PW'(8), 1'b1, 2'd1, 48'd7, 1'b1, 1'b0);
                default: applyStimulus(1'b1, PW'(8), 1'b0, 2'd0, 48'd0, 1'b1, 1'b0);
            endcase
            #1;
            checkOutput("p1_tick_pos", periodTick, i == 7);
            cycle();
        end
        checkBeats("p1", PW'(8), 48'd9, 48'd7, CLRV, CLRV);
        for (int k = 4; k < 8; k++) begin
            applyStimulus(1'b1, PW'(8), k == 7, 2'd2, 48'd100, 1'b1, 1'b0);
            cycle();
        end
        checkBeats("p2", PW'(8), CLRV, CLRV, 48'd100, CLRV);
        for (int k = 4; k < 8; k++) begin
            applyStimulus(1'b1, PW'(8), 1'b0, '0, '0, 1'b1, 1'b0);
            cycle();
        end
        checkBeats("p2_next", PW'(8), CLRV, CLRV, CLRV, CLRV);

        // Plan 3: stalled readout, overrun, clear.
        for (int k = 0; k < 20; k++) begin
            if (k == 0) applyStimulus(1'b1, PW'(8), 1'b1, 2'd3, 48'h1234, 1'b0, 1'b0);
            else if (k == 5) applyStimulus(1'b1, PW'(8), 1'b1, 2'd3, 48'hFFFF, 1'b0, 1'b0);
            else applyStimulus(1'b1, PW'(8), 1'b0, '0, '0, 1'b0, 1'b0);
            cycle();
        end
        checkOutput("p3_ovr_set", overrun, 1'b1);
        checkBeats("p3", PW'(8), CLRV, CLRV, CLRV, 48'h1234);
        applyStimulus(1'b1, PW'(8), 1'b0, '0, '0, 1'b1, 1'b1);
        cycle();
        checkOutput("p3_ovr_clr", overrun, 1'b0);

        // Plan 4: minimum period, then a mid-period length change.
        applyStimulus(1'b0, PW'(0), 1'b0, '0, '0, 1'b1, 1'b0);
        cycle();
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, PW'(0), 1'b0, '0, '0, 1'b1, 1'b0);
            #1;
            checkOutput("p4_tick2", periodTick, (k % 2) == 1);
            cycle();
        end
        applyStimulus(1'b0, PW'(8), 1'b0, '0, '0, 1'b1, 1'b0);
        cycle();
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1'b1, (k < 3) ? PW'(8) : PW'(4), 1'b0, '0, '0, 1'b1, 1'b0);
            #1;
            checkOutput("p4_tick_chg", periodTick, (k == 7) || (k == 11) || (k == 15));
            cycle();
        end

        // Plan 5: drop enable during a readout, then re-enable.
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b1, PW'(4), 1'b1, 2'd1, 48'h77, 1'b1, 1'b0);
            cycle();
        end
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, PW'(4), 1'b0, '0, '0, 1'b1, 1'b0);
            #1;
            checkOutput("p5_no_tick", periodTick, 1'b0);
            if (k == 0) checkOutput("p5_readout_live", outValid, 1'b1);
            cycle();
        end
        checkOutput("p5_readout_done", outValid, 1'b0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, PW'(4), 1'b0, '0, '0, 1'b1, 1'b0);
            #1;
            checkOutput("p5_first_tick", periodTick, k == 3);
            cycle();
        end
        checkBeats("p5", PW'(4), CLRV, CLRV, CLRV, CLRV);

`ifdef PEAK_SIGNED_EN
        // Plan 6: signed maxima and most-negative clear value.
        applyStimulus(1'b0, PW'(8), 1'b0, '0, '0, 1'b1, 1'b0);
        cycle();
        for (int k = 0; k < 8; k++) begin
            if (k == 0) applyStimulus(1'b1, PW'(8), 1'b1, 2'd0, -48'sd5, 1'b1, 1'b0);
            else if (k == 1) applyStimulus(1'b1, PW'(8), 1'b1, 2'd0, -48'sd2, 1'b1, 1'b0);
            else applyStimulus(1'b1, PW'(8), 1'b0, '0, '0, 1'b1, 1'b0);
            cycle();
        end
        checkBeats("p6", PW'(8), 48'hFFFF_FFFF_FFFE, 48'h8000_0000_0000,
                   48'h8000_0000_0000, 48'h8000_0000_0000);
`endif

        // Randomized traffic against the model.
        cfgR = PW'(6);
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 49) == 0) cfgR = PW'($urandom_range(0, 12));
            d = DW'({$urandom(), $urandom()});
            if ($urandom_range(0, 3) == 0) d = DW'($urandom_range(0, 15));
            applyStimulus($urandom_range(0, 19) != 0, cfgR, $urandom_range(0, 2) != 0,
                          CHW'($urandom()), d, $urandom_range(0, 9) < 7,
                          $urandom_range(0, 19) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule

// File: doc/peak_period_ctrl.md
Name: peak_period_ctrl

Overview:
Period scheduler and readout arbiter for multi-channel peak-hold tracking.
- Generates the 1 ms integration strobe internally, instead of relying on an external ms_in.
- Tracks per-channel maxima of a time-multiplexed 48-bit power stream using one shared comparator.
- At each period boundary, snapshots all channel maxima into a hold bank and streams them out over a valid/ready port to the register/packetiser side.

Parameters:
NCH, 4, number of channels (power of 2, 2..16)
DW, 48, sample/maximum width
CHW, 2, channel index width, log2(NCH)
PW, 18, period counter width
PERIOD_DEF, 150000, period length in clocks after reset (1 ms at 150 MHz)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
en  in  1  run enable
cfg_period  in  PW  period length in clocks
in_valid  in  1  sample strobe
in_ch  in  CHW  channel of sample
in_data  in  DW  sample value
period_tick  out  1  one-cycle pulse on last cycle of each period
out_valid  out  1  readout beat valid
out_ready  in  1  readout beat accepted
out_ch  out  CHW  channel of current beat
out_max  out  DW  held maximum of out_ch
out_last  out  1  high on beat for channel NCH-1
overrun  out  1  sticky: snapshot dropped
clr_ovr  in  1  clears overrun

Behaviour:
- Reset: count=0, plen=PERIOD_DEF, inner_max[*]=0, hold[*]=0, FSM=IDLE, period_tick=0, out_valid=0, out_ch=0, out_max=0, out_last=0, overrun=0.
- Period counter:
  - en=1: count runs 0..plen-1, then wraps to 0.
  - period_tick is combinational: en && count==plen-1.
  - plen reloads from cfg_period on each tick and while en=0. cfg_period<2 is treated as 2.
- en=0: count held at 0, no ticks, inner_max[*] cleared. An in-progress readout still completes.
- Tracking, non-tick cycle: if in_valid && in_data>inner_max[in_ch] (unsigned), then inner_max[in_ch]<=in_data.
- Tick cycle:
  - snap[c] = max(inner_max[c], in_data if in_valid && in_ch==c). A sample arriving in the tick cycle belongs to the ending period.
  - If FSM=IDLE: hold[c]<=snap[c] for all c.
  - Always: inner_max[*]<=0.
- Readout FSM states IDLE, SEND.
  - IDLE -> SEND on tick, with out_ch=0.
  - out_valid asserts the cycle after the tick.
  - In SEND: out_valid=1, out_max=hold[out_ch], out_last=(out_ch==NCH-1).
  - Beat transfers when out_valid&&out_ready; then out_ch increments.
  - After the last beat: SEND -> IDLE, out_valid=0 the next cycle.
  - out_ready low holds all outputs stable; no timeout.
- Overrun: a tick while FSM=SEND leaves hold untouched and the readout continues unchanged. That snapshot is discarded and overrun<=1.
  - clr_ovr clears overrun; a simultaneous overrun event wins (flag stays set).
- Back-to-back: if the tick falls in the same cycle as the last beat transfer, the FSM is still SEND. The snapshot is therefore dropped and overrun is set.
- rst mid-readout aborts immediately to reset values; no partial beats after reset.
- Pipelining: one compare per cycle; no stall on in_valid; no input backpressure.

Optional Feature:
PEAK_SIGNED_EN
- Defined: in_data, inner_max and hold are two's complement and all compares are signed. The clear/reset value of inner_max and hold is the most negative number, 1 followed by DW-1 zeros.
- Undefined: unsigned compares, clear value 0.
- Period, FSM and handshake timing are identical in both builds.

Test Plan:
1. rst, en=1, cfg_period=8, out_ready=1, in_valid every cycle, ch0 data 5,9,3 and ch1 data 7, others none -> tick at cycle 7, then beats (0,9),(1,7),(2,0),(3,0) on consecutive cycles, out_last on the 4th beat.
2. Tick-cycle sample: ch2 data 100 exactly on the tick cycle -> appears in the ending period's readout as (2,100); the next period's ch2 max reads 0 if no further samples.
3. cfg_period=8, out_ready=0 for 20 cycles -> second tick sets overrun, first snapshot still read out intact after out_ready=1. Then clr_ovr -> overrun=0.
4. cfg_period=0 -> period behaves as 2: ticks every 2nd cycle. Change cfg_period from 8 to 4 mid-period -> new length takes effect only after the next tick.
5. en dropped mid-period while a readout is active -> readout completes, no further ticks, inner_max cleared. en re-raised -> first tick after plen cycles.
6. PEAK_SIGNED_EN build: ch0 samples -5, -2 (48-bit) -> out_max=-2. Channel with no samples reads 0x8000_0000_0000.
